// File: rtl/pulse_density_gen.sv
// Pulse-density stream generator: emits exactly `density` ones per WINDOW cycles,
// spread evenly by a first-order accumulator, with lead-in wait, run length and abort.
module pulse_density_gen #(
    parameter int WINDOW      = 5000,
    parameter int CNT_W       = 15,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] density,
    input  logic [15:0]      n_windows,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [15:0]      win_cnt
);

    localparam int ACC_W  = CNT_W + 1;
    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_GEN  = 2'd2;

    localparam logic [CNT_W-1:0]  WIN_D     = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [ACC_W-1:0]  WIN_A     = ACC_W'(WINDOW);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_dens;
    logic [15:0]       r_nwin;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_phase;
    logic [WAIT_W-1:0] r_wait;

    logic [CNT_W-1:0] w_dclamp;
    logic [CNT_W-1:0] w_d_sel;
    logic [ACC_W-1:0] w_acc_sel;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_nx;
    logic             w_hit;
    logic             w_last_win;

    // The bit for the phase being entered is computed one edge early so that
    // the registered output lines up with the phase it belongs to. Entering
    // phase 0 (from IDLE, WAIT or a window wrap) always starts from acc=0.
    always_comb begin
        w_dclamp   = (density > WIN_D) ? WIN_D : density;
        w_d_sel    = (r_state == S_IDLE) ? w_dclamp : r_dens;
        w_acc_sel  = (r_state == S_GEN) ? r_acc : '0;
        w_sum      = w_acc_sel + {1'b0, w_d_sel};
        w_hit      = (w_sum >= WIN_A);
        w_acc_nx   = w_hit ? (w_sum - WIN_A) : w_sum;
        w_last_win = (r_nwin != '0) && ((win_cnt + 16'd1) == r_nwin);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_dens  <= '0;
            r_nwin  <= '0;
            r_acc   <= '0;
            r_phase <= '0;
            r_wait  <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            win_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    out <= 1'b0;
                    if (start && !stop) begin
                        r_dens  <= w_dclamp;
                        r_nwin  <= n_windows;
                        win_cnt <= '0;
                        r_phase <= '0;
                        r_wait  <= '0;
                        busy    <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= S_WAIT;
                            r_acc   <= '0;
                        end else begin
                            r_state <= S_GEN;
                            out     <= w_hit;
                            r_acc   <= w_acc_nx;
                        end
                    end
                end
                S_WAIT: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        out     <= 1'b0;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state <= S_GEN;
                        r_phase <= '0;
                        out     <= w_hit;
                        r_acc   <= w_acc_nx;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_GEN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        out     <= 1'b0;
                    end else if (r_phase == WIN_LAST) begin
                        r_phase <= '0;
                        win_cnt <= win_cnt + 16'd1;
                        if (w_last_win) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            out     <= 1'b0;
                            r_acc   <= '0;
                        end else begin
                            out   <= w_hit;
                            r_acc <= w_acc_nx;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                        out     <= w_hit;
                        r_acc   <= w_acc_nx;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    out     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_density_gen.sv
// Bench for pulse_density_gen: table runs, random runs against an arithmetic
// model of the expected stream, plus continuous/stop, ignored-start and async reset.
module tb_pulse_density_gen;

    localparam int W  = 10;
    localparam int CW = 5;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          start0 = 1'b0;
    logic          start4 = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] density = '0;
    logic [15:0]   n_windows = '0;

    logic        out0, busy0, done0;
    logic [15:0] wc0;
    logic        out4, busy4, done4;
    logic [15:0] wc4;

    int total = 0;
    int bad = 0;

    pulse_density_gen #(.WINDOW(W), .CNT_W(CW), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .start(start0), .stop(stop),
        .density(density), .n_windows(n_windows),
        .out(out0), .busy(busy0), .done(done0), .win_cnt(wc0)
    );

    pulse_density_gen #(.WINDOW(W), .CNT_W(CW), .WAIT_CYCLES(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .start(start4), .stop(stop),
        .density(density), .n_windows(n_windows),
        .out(out4), .busy(busy4), .done(done4), .win_cnt(wc4)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int d;
        int n;
        bit use_wait;
        int exp_ones;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bit at phase k of a window for clamped density dc.
    function automatic bit exp_bit(input int k, input int dc);
        return (((k + 1) * dc) / W) > ((k * dc) / W);
    endfunction

    // One complete run; every cycle's {out,busy,done,win_cnt} compared with the model.
    task automatic run_check(input int d, input int n, input bit w, input bit mid, input int exp_ones);
        int wt;
        int dc;
        int gen;
        int ones;
        int k;
        logic [18:0] ev;
        logic [18:0] av;
        wt   = w ? 4 : 0;
        dc   = (d > W) ? W : d;
        gen  = n * W;
        ones = 0;
        @(negedge CLK);
        density   = CW'(d);
        n_windows = 16'(n);
        if (w) start4 = 1'b1; else start0 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        start4 = 1'b0;
        for (int c = 1; c <= wt + gen + 2; c++) begin
            if (c <= wt) begin
                ev = {1'b0, 1'b1, 1'b0, 16'd0};
            end else if (c <= wt + gen) begin
                k  = c - wt - 1;
                ev = {exp_bit(k % W, dc), 1'b1, 1'b0, 16'(k / W)};
            end else begin
                ev = {1'b0, 1'b0, (c == wt + gen + 1), 16'(n)};
            end
            av = w ? {out4, busy4, done4, wc4} : {out0, busy0, done0, wc0};
            chk($sformatf("run d=%0d n=%0d w=%0d c=%0d", d, n, w, c), 32'(av), 32'(ev));
            ones += int'(av[18]);
            if (mid && c == 3) begin
                if (w) start4 = 1'b1; else start0 = 1'b1;
                density   = CW'(d ^ 5);
                n_windows = 16'(n + 3);
            end
            if (mid && c == 4) begin
                start0 = 1'b0;
                start4 = 1'b0;
            end
            @(negedge CLK);
        end
        chk($sformatf("ones d=%0d n=%0d", d, n), 32'(ones), 32'(exp_ones));
    endtask

    vec_t vecs[5];
    int   wones;
    int   rd, rn;
    bit   rw;
    logic [18:0] ev2;

    initial begin
        vecs[0] = '{d: 3,  n: 2, use_wait: 1'b0, exp_ones: 6};
        vecs[1] = '{d: 0,  n: 1, use_wait: 1'b0, exp_ones: 0};
        vecs[2] = '{d: 10, n: 1, use_wait: 1'b0, exp_ones: 10};
        vecs[3] = '{d: 15, n: 1, use_wait: 1'b1, exp_ones: 10};
        vecs[4] = '{d: 5,  n: 1, use_wait: 1'b1, exp_ones: 5};

        repeat (3) @(negedge CLK);
        chk("reset dut0", 32'({out0, busy0, done0, wc0}), 32'd0);
        chk("reset dut4", 32'({out4, busy4, done4, wc4}), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 5; i++)
            run_check(vecs[i].d, vecs[i].n, vecs[i].use_wait, 1'b0, vecs[i].exp_ones);

        // Start pulsed mid-run with new density/n_windows: must be ignored.
        run_check(3, 1, 1'b0, 1'b1, 3);
        run_check(7, 1, 1'b1, 1'b1, 7);

        for (int i = 0; i < 8; i++) begin
            rd = $urandom_range(0, 20);
            rn = $urandom_range(1, 3);
            rw = 1'($urandom_range(0, 1));
            run_check(rd, rn, rw, 1'b0, ((rd > W) ? W : rd) * rn);
        end

        // start and stop together in IDLE: stays idle, win_cnt keeps last run's value.
        @(negedge CLK);
        density = 5'd4; n_windows = 16'd1; start0 = 1'b1; stop = 1'b1;
        @(negedge CLK);
        start0 = 1'b0; stop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("start+stop idle", 32'({out0, busy0, done0}), 32'd0);
            @(negedge CLK);
        end

        // Continuous mode, 50 windows, then stop.
        density = 5'd7; n_windows = 16'd0; start0 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        wones = 0;
        for (int c = 1; c <= 501; c++) begin
            ev2 = {exp_bit((c - 1) % W, 7), 1'b1, 1'b0, 16'((c - 1) / W)};
            chk($sformatf("cont c=%0d", c), 32'({out0, busy0, done0, wc0}), 32'(ev2));
            wones += int'(out0);
            if (c % W == 0) begin
                chk($sformatf("cont window %0d ones", c / W), 32'(wones), 32'd7);
                wones = 0;
            end
            if (c == 501) stop = 1'b1;
            @(negedge CLK);
        end
        stop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("after stop", 32'({out0, busy0, done0, wc0}), 32'({1'b0, 1'b0, 1'b0, 16'd50}));
            @(negedge CLK);
        end

        // Asynchronous reset in the middle of GEN.
        density = 5'd3; n_windows = 16'd0; start0 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        repeat (13) @(negedge CLK);
        chk("pre-reset state", 32'({out0, busy0, done0, wc0}), 32'({1'b1, 1'b1, 1'b0, 16'd1}));
        #2 RST_N = 1'b0;
        #1 chk("async reset", 32'({out0, busy0, done0, wc0}), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_check(5, 1, 1'b0, 1'b0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
